// File: rtl/data_stream_hs_pkg.sv
// ============================================================================
//  Module      : data_stream_hs_pkg
//  Description : Shared constants and strobe popcount helper for the stream sink.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_stream_hs_pkg;

    localparam int CNT_WIDTH = 32;
    // Widest strobe vector supported by the popcount helper (DATA_WIDTH <= 512).
    localparam int STRB_MAX  = 64;

    function automatic logic [CNT_WIDTH-1:0] strb_popcount(input logic [STRB_MAX-1:0] strb);
        logic [CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < STRB_MAX; i++) begin
            cnt = cnt + CNT_WIDTH'(strb[i]);
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_stream_hs_sink.sv
// ============================================================================
//  Module      : data_stream_hs_sink
//  Description : Valid/ready stream sink feeding a FWFT buffer with byte counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_stream_hs_sink
    import data_stream_hs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int LVL_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [STRB_WIDTH-1:0] s_strb,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [STRB_WIDTH-1:0] rd_strb,
    output logic                  rd_valid,
    output logic [LVL_WIDTH-1:0]  level,
    output logic [CNT_WIDTH-1:0]  byte_cnt,
    input  logic                  clr_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LVL_WIDTH-1:0] FULL_LVL = LVL_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [STRB_WIDTH-1:0] strb_mem [DEPTH];

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 push;
    logic                 pop;
    logic [LVL_WIDTH-1:0] level_nxt;
    logic [STRB_MAX-1:0]  strb_ext;
    logic [CNT_WIDTH-1:0] beat_bytes;
    logic [CNT_WIDTH:0]   cnt_sum;
    logic [CNT_WIDTH-1:0] cnt_nxt;

    assign push     = s_valid && s_ready;
    assign pop      = rd_en && rd_valid;
    assign rd_valid = (level != '0);
    assign rd_data  = data_mem[rd_ptr];
    assign rd_strb  = strb_mem[rd_ptr];

    assign level_nxt  = level + LVL_WIDTH'(push) - LVL_WIDTH'(pop);
    assign strb_ext   = STRB_MAX'(s_strb);
    assign beat_bytes = strb_popcount(strb_ext);
    assign cnt_sum    = {1'b0, byte_cnt} + {1'b0, beat_bytes};

    always_comb begin
        cnt_nxt = byte_cnt;
        if (clr_cnt) begin
            cnt_nxt = push ? beat_bytes : '0;
        end else if (push) begin
            // Saturate rather than wrap on carry out.
            cnt_nxt = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        end
    end

    // Ready is registered from the next level, so a pop never frees a slot in
    // the same cycle it happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            s_ready  <= 1'b0;
            byte_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= level_nxt;
            s_ready  <= (level_nxt != FULL_LVL);
            byte_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= s_data;
            strb_mem[wr_ptr] <= s_strb;
        end
    end

endmodule

`default_nettype wire

// File: doc/data_stream_hs_sink.md
DATA_STREAM_HS_SINK -- requirements
Module: data_stream_hs_sink

Interface
REQ-001 Parameter DATA_WIDTH, default 32: stream data width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter DEPTH, default 16: buffer entries; SHALL be a power of 2, minimum 2.
REQ-003 Derived constants: STRB_WIDTH = DATA_WIDTH/8; LVL_WIDTH = $clog2(DEPTH)+1.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 s_data  input  DATA_WIDTH  stream data from the master.
REQ-007 s_strb  input  STRB_WIDTH  byte strobes; bit i qualifies s_data[8i+7:8i].
REQ-008 s_valid  input  1  master beat valid.
REQ-009 s_ready  output  1  sink can accept a beat.
REQ-010 rd_en  input  1  pop head entry (local reader).
REQ-011 rd_data  output  DATA_WIDTH  head entry data, first-word-fall-through.
REQ-012 rd_strb  output  STRB_WIDTH  head entry strobes.
REQ-013 rd_valid  output  1  head entry present (buffer not empty).
REQ-014 level  output  LVL_WIDTH  occupied entries, 0..DEPTH.
REQ-015 byte_cnt  output  32  total accepted bytes since reset/clear.
REQ-016 clr_cnt  input  1  synchronous clear of byte_cnt.

Function
REQ-017 A beat SHALL be accepted on a rising edge where s_valid && s_ready; s_data and s_strb are written at the tail.
REQ-018 s_ready SHALL be a register: next value = (next level != DEPTH); no combinational path from s_valid or rd_en to s_ready.
REQ-019 Full (level == DEPTH): s_ready SHALL be 0; a same-cycle pop SHALL NOT enable a same-cycle push; s_ready returns to 1 the cycle after the pop.
REQ-020 rd_valid SHALL equal (level != 0); rd_data/rd_strb SHALL show the head entry combinationally from storage, valid 1 cycle after the push edge (push-to-read latency 1).
REQ-021 Pop occurs on a rising edge where rd_en && rd_valid; rd_en while rd_valid == 0 SHALL be ignored, no state change.
REQ-022 Simultaneous push and pop (non-empty, not full): both SHALL take effect; level unchanged.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; level SHALL track push minus pop exactly.
REQ-024 Beats with s_strb == 0 SHALL be stored and popped like any beat; they add 0 to byte_cnt.
REQ-025 byte_cnt SHALL add popcount(s_strb) per accepted beat; saturate at 32'hFFFF_FFFF, no wrap.
REQ-026 clr_cnt == 1: byte_cnt next = popcount(s_strb) if a beat is accepted that edge, else 0.
REQ-027 s_data/s_strb SHALL be sampled only on accept; values while s_valid == 0 SHALL have no effect.
REQ-028 Stream ordering SHALL be preserved; no beat dropped or duplicated.

Reset
REQ-029 While rst_n == 0: s_ready = 0, rd_valid = 0, level = 0, byte_cnt = 0, pointers = 0.
REQ-030 s_ready SHALL rise at the first rising edge after rst_n deasserts.
REQ-031 Storage array SHALL NOT be reset; rd_data/rd_strb are don't-care while rd_valid == 0.
REQ-032 Reset mid-operation SHALL discard all buffered beats; a beat presented during reset is not accepted.

Structure
REQ-033 Shared package data_stream_hs_pkg SHALL hold the strobe popcount function and the byte_cnt width constant (32).
REQ-034 No sub-module: pointers, level, storage and counter are in this module.

Verification (DATA_WIDTH=32, DEPTH=4)
REQ-035 Reset release, s_valid=0 -> s_ready 0 during reset, 1 one edge after release; rd_valid 0; level 0; byte_cnt 0.
REQ-036 Push 0xA0..0xA3 (strb 4'hF), rd_en=0 -> level 4, s_ready 0, byte_cnt 16; fifth beat 0xA4 held until one pop, then accepted; pops return A0,A1,A2,A3,A4.
REQ-037 Continuous push and pop, level 2, 20 beats -> level stays 2; data order intact; pointers wrap 5 times.
REQ-038 Strobes 4'b0001, 4'b0110, 4'b0000, 4'b1111 -> byte_cnt 1,3,3,7; all four beats popped with matching rd_strb.
REQ-039 byte_cnt preloaded to 0xFFFF_FFFE by forcing, push strb 4'hF -> 0xFFFF_FFFF; clr_cnt with strb 4'h3 beat same edge -> 2.
REQ-040 rst_n pulsed low with level 3 -> level 0, rd_valid 0 immediately; rd_en ignored until a new push.
